// File: rtl/adc_float_feeder.sv
// ADC pair capture, shift-normalise to IEEE-754 single, and start/ACK handshake
// toward the linearise-normalise core. Build option: OFFSET_BINARY_EN (signed offset-binary codes).
module adc_float_feeder #(
    parameter int W       = 12,
    parameter int P       = 32,
    parameter int TIMEOUT = 4000
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] ADC_I,
    input  logic [W-1:0] ADC_V,
    input  logic         DATA_VALID,
    output logic         READY,
    output logic [P-1:0] I_OUT,
    output logic [P-1:0] V_OUT,
    output logic         BEGIN_FSM_I,
    output logic         BEGIN_FSM_V,
    input  logic         ACK_I,
    input  logic         ACK_V,
    output logic         OVERRUN,
    output logic         TIMEOUT_F,
    input  logic         CLR_FLAGS
);

    localparam int SW = (W > 1) ? $clog2(W) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t          state_q;
    logic [P-1:0]    i_out_q;
    logic [P-1:0]    v_out_q;
    logic            begin_q;
    logic            overrun_q;
    logic            timeout_q;
    logic            seen_i_q;
    logic            seen_v_q;
    logic [TW-1:0]   cnt_q;

    logic [1:0]      done;
    logic [1:0][31:0] flt;
    logic [1:0][W-1:0] code;

    assign code[0] = ADC_I;
    assign code[1] = ADC_V;

    // Channel 0 is current, channel 1 is voltage; both normalise in lockstep.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [W-1:0]  mag_q;
            logic [W-1:0]  mag_d;
            logic          sgn_q;
            logic          sgn_d;
            logic [SW-1:0] s_q;
            logic [SW-1:0] s_d;
            logic [W-1:0]  mag_load;
            logic          sgn_load;
            logic [22:0]   mant;
            logic [7:0]    expo;

`ifdef OFFSET_BINARY_EN
            localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
            always_comb begin
                if (code[gi] < HALF) begin
                    sgn_load = 1'b1;
                    mag_load = HALF - code[gi];
                end else begin
                    sgn_load = 1'b0;
                    mag_load = code[gi] - HALF;
                end
            end
`else
            always_comb begin
                sgn_load = 1'b0;
                mag_load = code[gi];
            end
`endif

            assign done[gi] = (mag_q == '0) || mag_q[W-1];

            always_comb begin
                mag_d = mag_q;
                sgn_d = sgn_q;
                s_d   = s_q;
                if (state_q == S_IDLE && DATA_VALID) begin
                    mag_d = mag_load;
                    sgn_d = sgn_load;
                    s_d   = '0;
                end else if (state_q == S_NORM && !done[gi]) begin
                    mag_d = {mag_q[W-2:0], 1'b0};
                    s_d   = s_q + 1'b1;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    mag_q <= '0;
                    sgn_q <= 1'b0;
                    s_q   <= '0;
                end else begin
                    mag_q <= mag_d;
                    sgn_q <= sgn_d;
                    s_q   <= s_d;
                end
            end

            // Leading one is implicit; remaining W-1 bits are left-justified in the fraction.
            always_comb begin
                mant            = '0;
                mant[22 -: W-1] = mag_q[W-2:0];
                expo            = 8'(127 + W - 1) - 8'(s_q);
                if (mag_q == '0) begin
                    flt[gi] = 32'h0000_0000;
                end else begin
                    flt[gi] = {sgn_q, expo, mant};
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            i_out_q   <= '0;
            v_out_q   <= '0;
            begin_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            seen_i_q  <= 1'b0;
            seen_v_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            begin_q <= 1'b0;
            if (DATA_VALID && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (DATA_VALID) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (&done) begin
                        i_out_q <= P'(flt[0]);
                        v_out_q <= P'(flt[1]);
                        begin_q <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    seen_i_q <= 1'b0;
                    seen_v_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if ((seen_i_q || ACK_I) && (seen_v_q || ACK_V)) begin
                        seen_i_q <= 1'b0;
                        seen_v_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        seen_i_q  <= 1'b0;
                        seen_v_q  <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        seen_i_q <= seen_i_q || ACK_I;
                        seen_v_q <= seen_v_q || ACK_V;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Clearing wins over any set in the same cycle.
            if (CLR_FLAGS) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
        end
    end

    assign READY       = (state_q == S_IDLE);
    assign I_OUT       = i_out_q;
    assign V_OUT       = v_out_q;
    assign BEGIN_FSM_I = begin_q;
    assign BEGIN_FSM_V = begin_q;
    assign OVERRUN     = overrun_q;
    assign TIMEOUT_F   = timeout_q;

endmodule

// File: tb/tb_adc_float_feeder.sv
// Directed bench for adc_float_feeder (W=12, TIMEOUT=20); latency counts edges from the accept edge inclusive.
module tb_adc_float_feeder;

    localparam int W = 12;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [W-1:0]  ADC_I = '0;
    logic [W-1:0]  ADC_V = '0;
    logic          DATA_VALID = 1'b0;
    logic          READY;
    logic [31:0]   I_OUT;
    logic [31:0]   V_OUT;
    logic          BEGIN_FSM_I;
    logic          BEGIN_FSM_V;
    logic          ACK_I = 1'b0;
    logic          ACK_V = 1'b0;
    logic          OVERRUN;
    logic          TIMEOUT_F;
    logic          CLR_FLAGS = 1'b0;

    int checks = 0;
    int errors = 0;

    adc_float_feeder #(.W(W), .P(32), .TIMEOUT(20)) dut (
        .CLK(CLK), .RST_N(RST_N), .ADC_I(ADC_I), .ADC_V(ADC_V),
        .DATA_VALID(DATA_VALID), .READY(READY), .I_OUT(I_OUT), .V_OUT(V_OUT),
        .BEGIN_FSM_I(BEGIN_FSM_I), .BEGIN_FSM_V(BEGIN_FSM_V),
        .ACK_I(ACK_I), .ACK_V(ACK_V), .OVERRUN(OVERRUN), .TIMEOUT_F(TIMEOUT_F),
        .CLR_FLAGS(CLR_FLAGS)
    );

    always #5 CLK = ~CLK;

    // Presents a pair for one cycle; lat = edges from accept edge to the edge raising BEGIN, -1 if none.
    task automatic send_pair(input logic [W-1:0] ai, input logic [W-1:0] av, output int lat);
        ADC_I = ai;
        ADC_V = av;
        DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        lat = 1;
        while (!BEGIN_FSM_I && lat < 200) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!BEGIN_FSM_I) lat = -1;
        $display("pair ADC_I=%h ADC_V=%h lat=%0d I_OUT=%h V_OUT=%h", ai, av, lat, I_OUT, V_OUT);
    endtask

    // Holds both ACKs until READY returns; ok=0 if it never does.
    task automatic ack_both(output bit ok);
        int n;
        ACK_I = 1'b1;
        ACK_V = 1'b1;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!READY && n < 100);
        ACK_I = 1'b0;
        ACK_V = 1'b0;
        ok = READY;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", READY); end
        checks++; if (I_OUT !== 32'h0) begin errors++; $display("FAIL reset_i_out got %h exp 00000000", I_OUT); end
        checks++; if (V_OUT !== 32'h0) begin errors++; $display("FAIL reset_v_out got %h exp 00000000", V_OUT); end
        checks++; if ({BEGIN_FSM_I, BEGIN_FSM_V} !== 2'b00) begin errors++; $display("FAIL reset_begin got %b exp 00", {BEGIN_FSM_I, BEGIN_FSM_V}); end
        checks++; if ({OVERRUN, TIMEOUT_F} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {OVERRUN, TIMEOUT_F}); end
        RST_N = 1'b1;
        @(posedge CLK); #1;
        checks++; if (READY !== 1'b1 || BEGIN_FSM_I !== 1'b0) begin errors++; $display("FAIL reset_release got ready=%b begin=%b exp 1/0", READY, BEGIN_FSM_I); end
        $display("reset done");
    endtask

    task automatic test_conversion;
        int lat;
        bit ok;
        send_pair(12'h800, 12'h001, lat);
        checks++; if (lat != 13) begin errors++; $display("FAIL conv_latency got %0d exp 13", lat); end
        checks++; if (I_OUT !== 32'h4500_0000) begin errors++; $display("FAIL conv_i_out got %h exp 45000000", I_OUT); end
        checks++; if (V_OUT !== 32'h3F80_0000) begin errors++; $display("FAIL conv_v_out got %h exp 3f800000", V_OUT); end
        checks++; if (BEGIN_FSM_V !== 1'b1) begin errors++; $display("FAIL conv_begin_v got %b exp 1", BEGIN_FSM_V); end
        @(posedge CLK); #1;
        checks++; if ({BEGIN_FSM_I, BEGIN_FSM_V} !== 2'b00) begin errors++; $display("FAIL conv_pulse_width got %b exp 00", {BEGIN_FSM_I, BEGIN_FSM_V}); end
        ack_both(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL conv_ready_return got %b exp 1", ok); end
    endtask

    task automatic test_full_zero;
        int lat;
        bit ok;
        send_pair(12'hFFF, 12'h000, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL fz_latency got %0d exp 2", lat); end
        checks++; if (I_OUT !== 32'h457F_F000) begin errors++; $display("FAIL fz_i_out got %h exp 457ff000", I_OUT); end
        checks++; if (V_OUT !== 32'h0000_0000) begin errors++; $display("FAIL fz_v_out got %h exp 00000000", V_OUT); end
        ack_both(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fz_ready_return got %b exp 1", ok); end
    endtask

    task automatic test_skewed_ack;
        int lat;
        int extra_begin;
        send_pair(12'h123, 12'h456, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL skew_latency got %0d exp 5", lat); end
        extra_begin = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge CLK); #1;
            if (BEGIN_FSM_I || BEGIN_FSM_V) extra_begin++;
            checks++; if (READY !== 1'b0) begin errors++; $display("FAIL skew_ready_early k=%0d got %b exp 0", k, READY); end
            checks++; if (I_OUT !== 32'h4391_8000 || V_OUT !== 32'h448A_C000) begin
                errors++; $display("FAIL skew_hold k=%0d got %h/%h exp 43918000/448ac000", k, I_OUT, V_OUT);
            end
            if (k == 3) ACK_I = 1'b1;
            if (k == 7) ACK_V = 1'b1;
        end
        @(posedge CLK); #1;
        ACK_V = 1'b0;
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL skew_ready got %b exp 1", READY); end
        ACK_I = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (BEGIN_FSM_I || BEGIN_FSM_V) extra_begin++;
        end
        checks++; if (extra_begin != 0) begin errors++; $display("FAIL skew_second_begin got %0d exp 0", extra_begin); end
        checks++; if (I_OUT !== 32'h4391_8000) begin errors++; $display("FAIL skew_hold_idle got %h exp 43918000", I_OUT); end
    endtask

    task automatic test_timeout_overrun;
        int lat;
        int waits;
        bit ok;
        // Overrun: extra DATA_VALID cycle while normalising
        ADC_I = 12'h001;
        ADC_V = 12'h002;
        DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b exp 0", OVERRUN); end
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", OVERRUN); end
        // Clear takes priority over a simultaneous overrun
        DATA_VALID = 1'b1;
        CLR_FLAGS = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        CLR_FLAGS = 1'b0;
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_clr_priority got %b exp 0", OVERRUN); end
        lat = 3;
        while (!BEGIN_FSM_I && lat < 200) begin
            @(posedge CLK); #1;
            lat++;
        end
        checks++; if (lat != 13) begin errors++; $display("FAIL ovr_latency got %0d exp 13", lat); end
        ack_both(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovr_ready_return got %b exp 1", ok); end
        $display("overrun pair done OVERRUN=%b", OVERRUN);

        // Timeout: no ACKs at all
        send_pair(12'h010, 12'h020, lat);
        checks++; if (I_OUT !== 32'h4180_0000 || V_OUT !== 32'h4200_0000) begin
            errors++; $display("FAIL to_values got %h/%h exp 41800000/42000000", I_OUT, V_OUT);
        end
        @(posedge CLK); #1;
        waits = 0;
        while (!READY && waits < 100) begin
            waits++;
            checks++; if (TIMEOUT_F !== 1'b0) begin errors++; $display("FAIL to_early wait=%0d got %b exp 0", waits, TIMEOUT_F); end
            @(posedge CLK); #1;
        end
        checks++; if (waits != 20) begin errors++; $display("FAIL to_wait_cycles got %0d exp 20", waits); end
        checks++; if (TIMEOUT_F !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", TIMEOUT_F); end
        DATA_VALID = 1'b1;
        ADC_I = 12'h010;
        ADC_V = 12'h020;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        @(posedge CLK); #1;
        OVERRUN_SETUP: begin end
        DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        checks++; if ({OVERRUN, TIMEOUT_F} !== 2'b11) begin errors++; $display("FAIL flags_both got %b exp 11", {OVERRUN, TIMEOUT_F}); end
        CLR_FLAGS = 1'b1;
        @(posedge CLK); #1;
        CLR_FLAGS = 1'b0;
        checks++; if ({OVERRUN, TIMEOUT_F} !== 2'b00) begin errors++; $display("FAIL flags_clear got %b exp 00", {OVERRUN, TIMEOUT_F}); end
        waits = 0;
        while (!BEGIN_FSM_I && waits < 100) begin @(posedge CLK); #1; waits++; end
        ack_both(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_recover got %b exp 1", ok); end
    endtask

    task automatic test_reset_mid_norm;
        int lat;
        int begins;
        bit ok;
        ADC_I = 12'h000;
        ADC_V = 12'h001;
        DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        checks++; if (I_OUT !== 32'h0 || V_OUT !== 32'h0) begin errors++; $display("FAIL rst_mid_outs got %h/%h exp 0/0", I_OUT, V_OUT); end
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", READY); end
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        begins = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (BEGIN_FSM_I || BEGIN_FSM_V) begins++;
        end
        checks++; if (begins != 0) begin errors++; $display("FAIL rst_mid_begin got %0d exp 0", begins); end
        checks++; if ({OVERRUN, TIMEOUT_F, READY} !== 3'b001) begin errors++; $display("FAIL rst_mid_state got %b exp 001", {OVERRUN, TIMEOUT_F, READY}); end
        $display("reset mid-norm done");
        send_pair(12'h800, 12'h001, lat);
        checks++; if (lat != 13) begin errors++; $display("FAIL rst_next_latency got %0d exp 13", lat); end
        checks++; if (I_OUT !== 32'h4500_0000 || V_OUT !== 32'h3F80_0000) begin
            errors++; $display("FAIL rst_next_values got %h/%h exp 45000000/3f800000", I_OUT, V_OUT);
        end
        ack_both(ok);
    endtask

    task automatic test_offset_binary;
        int lat;
        bit ok;
        send_pair(12'h000, 12'h800, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL ob_latency got %0d exp 2", lat); end
        checks++; if (I_OUT !== 32'hC500_0000) begin errors++; $display("FAIL ob_neg_full got %h exp c5000000", I_OUT); end
        checks++; if (V_OUT !== 32'h0000_0000) begin errors++; $display("FAIL ob_zero got %h exp 00000000", V_OUT); end
        ack_both(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ob_ready got %b exp 1", ok); end
        send_pair(12'hFFF, 12'h7FF, lat);
        checks++; if (I_OUT !== 32'h44FF_E000) begin errors++; $display("FAIL ob_pos_full got %h exp 44ffe000", I_OUT); end
        checks++; if (V_OUT !== 32'hBF80_0000) begin errors++; $display("FAIL ob_minus_one got %h exp bf800000", V_OUT); end
        checks++; if (lat != 13) begin errors++; $display("FAIL ob_latency2 got %0d exp 13", lat); end
        ack_both(ok);
    endtask

    initial begin
        test_reset;
`ifdef OFFSET_BINARY_EN
        test_offset_binary;
`else
        test_conversion;
        test_full_zero;
        test_skewed_ack;
        test_timeout_overrun;
        test_reset_mid_norm;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
